fetch_stage: RTL and testbench

Instruction fetch front-end of the pipelined processor: owns the PC and issues sequential reads to the instruction memory. It buffers returned words with their PCs in a small prefetch queue and hands them to decode over a valid/ready handshake. A redirect from execute (taken branch/jump) flushes the queue, kills the in-flight read and restarts fetch at the new PC.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end: default sizing,
// reset PC, the PC step and the {pc, instr} fetch entry layout.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W     = 32;
  localparam int unsigned FETCH_DATA_W     = 32;
  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = '0;
  localparam int unsigned PC_INC           = 4;

  // One prefetched instruction together with the address it was read from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO used as the fetch prefetch queue.
// Flush has priority over push/pop. Head data comes straight from storage,
// so the head is a registered value. DEPTH must be a power of two so the
// pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Next pointer/count values; a flush empties the queue outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: owns the fetch PC, issues one sequential
// instruction-memory read per cycle while queue credit allows, buffers the
// returned words with their PCs and presents the queue head to decode.
// A redirect flushes the queue, kills the in-flight read and restarts at
// redirect_pc. Optional performance counters are built when the macro
// FETCH_PERF_EN is defined.
//
// Handshake: an instruction transfers to decode on every rising edge where
// if_valid && id_ready. if_valid/if_pc/if_instr are registered and hold their
// values while id_ready is low; if_valid never drops without a transfer
// except on redirect or reset.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [15:0]           perf_redirects
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned UW = CW + 1;
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         fifo_count;
  logic [UW-1:0]         used;
  logic                  credit_ok;
  logic                  push, pop;
  logic [EW-1:0]         head;

  // Credit counts queued entries plus the outstanding read; a pop in the
  // same cycle is deliberately not credited, which keeps the path short.
  assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = used < UW'(DEPTH);

  assign imem_req  = reset && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc_q;

  // A redirect kills the returning read and voids any pop in that cycle.
  assign push = inflight_q && !redirect_valid;
  assign pop  = if_valid && id_ready && !redirect_valid;

  // Next fetch PC, PC of the outstanding read and in-flight flag.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_req) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_INC);
    end
  end

  // Fetch PC / in-flight tracking registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i ({req_pc_q, imem_rdata}),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign if_valid = (fifo_count != '0);
  assign if_pc    = head[EW-1:DATA_WIDTH];
  assign if_instr = head[DATA_WIDTH-1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubbles_q;
  logic [15:0] perf_redirects_q;

  // Bubble and redirect counters; both wrap silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bubbles_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (!if_valid)      perf_bubbles_q   <= perf_bubbles_q + 32'd1;
      if (redirect_valid) perf_redirects_q <= perf_redirects_q + 16'd1;
    end
  end

  assign perf_bubbles   = perf_bubbles_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A transaction-level reference model
// (expected queue of {pc, instr}, fetch PC and an outstanding-read flag)
// predicts every cycle; a vector table and hand sequences pin the startup,
// stall/drain, redirect and wrap corner cases with hand-derived values.
// Build with FETCH_PERF_EN defined to also check the perf counters.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubbles;
  logic [15:0] perf_redirects;
`endif

  fetch_stage #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_bubbles   (perf_bubbles),
    .perf_redirects (perf_redirects)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] exp_q[$];          // fetch_entry_t images, oldest first
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_pc;
  logic        m_exp_req;
  logic [31:0] m_bub;
  logic [15:0] m_redir;

  logic        cur_rv, cur_rdy;
  logic [31:0] cur_rpc;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {2'b10, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_inf   = 1'b0;
    m_pc    = RESET_PC;
    m_bub   = '0;
    m_redir = '0;
  endtask

  task automatic check_vs_model();
    fetch_entry_t e;
    m_exp_req = !cur_rv && ((exp_q.size() + int'(m_inf)) < int'(DEPTH));
    chk("imem_req", 32'(imem_req), 32'(m_exp_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = fetch_entry_t'(exp_q[0]);
      chk("if_pc", if_pc, e.pc);
      chk("if_instr", if_instr, e.instr);
    end
    chk("count_le_depth", 32'(dut.fifo_count <= 3'(DEPTH)), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_bubbles", perf_bubbles, m_bub);
    chk("perf_redirects", 32'(perf_redirects), 32'(m_redir));
`endif
  endtask

  task automatic model_edge();
    if (exp_q.size() == 0) m_bub++;
    if (cur_rv) begin
      exp_q.delete();
      m_inf = 1'b0;
      m_pc  = cur_rpc;
      m_redir++;
    end else begin
      if (cur_rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_inf) exp_q.push_back({m_inf_pc, imem_word(m_inf_pc)});
      m_inf = m_exp_req;
      if (m_exp_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: apply inputs and let them settle.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    cur_rv = rv; cur_rpc = rpc; cur_rdy = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
  endtask

  // Compare against the model, take the rising edge, answer the read.
  task automatic tick();
    logic        req_s;
    logic [31:0] addr_s;
    check_vs_model();
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge clk);
    model_edge();
    #1 imem_rdata = req_s ? imem_word(addr_s) : $urandom();
    @(negedge clk);
  endtask

  // One-cycle reset pulse with a redirect held high, which must be ignored.
  task automatic do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    id_ready       = 1'b1;
    reset          = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_bubbles", perf_bubbles, 32'd0);
    chk("rst_perf_redirects", 32'(perf_redirects), 32'd0);
`endif
    @(posedge clk);
    #1 imem_rdata = $urandom();
    @(negedge clk);
    chk("rst_hold_req", 32'(imem_req), 32'd0);
    chk("rst_hold_addr", imem_addr, RESET_PC);
    redirect_valid = 1'b0;
    reset          = 1'b1;
    model_clear();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Stall for 10 cycles from reset release, then drain.
    vecs[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    vecs[7]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    vecs[8]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    vecs[10] = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
    vecs[11] = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
    vecs[12] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
    vecs[13] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
    vecs[14] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
    vecs[15] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20};

    model_clear();
    cur_rv = 1'b0; cur_rpc = '0; cur_rdy = 1'b0;
    #2;
    do_reset();

    // Startup with decode always ready: one instruction per cycle.
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("start_req", 32'(imem_req), 32'd1);
      chk("start_addr", imem_addr, 32'(4 * c));
      chk("start_valid", 32'(if_valid), 32'(c >= 2));
      if (c >= 2) chk("start_pc", if_pc, 32'(4 * (c - 2)));
      tick();
    end

    // Mid-stream reset, then the stall/drain table from a clean start.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h0, vecs[i].rdy);
      chk("vec_req", 32'(imem_req), 32'(vecs[i].exp_req));
      chk("vec_addr", imem_addr, vecs[i].exp_addr);
      chk("vec_valid", 32'(if_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk("vec_pc", if_pc, vecs[i].exp_pc);
        chk("vec_instr", if_instr, imem_word(vecs[i].exp_pc));
      end
      tick();
    end

    // Redirect while the queue holds 3 entries and a read is in flight.
    drive(1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 32'h100, 1'b0);
    chk("redir_occupancy", 32'(dut.fifo_count), 32'd3);
    chk("redir_no_req", 32'(imem_req), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_bubble1", 32'(if_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_bubble2", 32'(if_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_valid", 32'(if_valid), 32'd1);
    chk("redir_pc0", if_pc, 32'h100);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_pc1", if_pc, 32'h104);
    tick();

    // Redirect together with a pop, then a second redirect: last one wins.
    drive(1'b1, 32'h200, 1'b1);
    chk("dbl_pop_pending", 32'(if_valid), 32'd1);
    tick();
    drive(1'b1, 32'h300, 1'b1);
    chk("dbl_no_req", 32'(imem_req), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("dbl_addr", imem_addr, 32'h300);
    chk("dbl_bubble1", 32'(if_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("dbl_bubble2", 32'(if_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("dbl_pc0", if_pc, 32'h300);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("dbl_pc1", if_pc, 32'h304);
    tick();

    // PC wrap at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    chk("wrap_req", 32'(imem_req), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("wrap_pc_zero", if_pc, 32'h0);
    tick();

    // Randomized traffic against the model, with one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic        rv, rdy;
      logic [31:0] rpc;
      if (i == 200) do_reset();
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else                           rpc = $urandom() & 32'hFFFF_FFFC;
      drive(rv, rpc, rdy);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
